// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  // Owner of the most recent grant.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    DBG  = 2'd2
  } arb_state_e;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_DBG  = 1;
  localparam int unsigned NUM_PORTS = 2;

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Up-counter that sticks at MAX; a clear takes precedence over an increment.
module dmem_arb_sat_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core/debug arbiter for the single-ported data memory with registered read return.
// Define DMEM_ARB_RR_EN for round-robin instead of fixed core priority on contention.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LOCK_MAX   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_valid,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ready,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);

  arb_state_e    state_q, state_d;
  logic          c_gnt, d_gnt;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lock_cnt;
  logic          lock_hold, starved;
  logic          c_rvalid_q, d_rvalid_q;
  logic [DW-1:0] c_rdata_q, d_rdata_q;

  assign lock_hold = (state_q == DBG) && d_lock && (lock_cnt < LW'(LOCK_MAX));
  assign starved   = (starve_cnt == SW'(STARVE_MAX));

  // Grant selection; reset suppresses every grant so the memory is left idle.
  always_comb begin
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    state_d = IDLE;
    if (rst) begin
      if (c_valid && d_valid) begin
        if (lock_hold || starved) begin
          d_gnt = 1'b1;
        end
`ifdef DMEM_ARB_RR_EN
        else if (state_q == CORE) begin
          d_gnt = 1'b1;
        end
`endif
        else begin
          c_gnt = 1'b1;
        end
      end else begin
        c_gnt = c_valid;
        d_gnt = d_valid;
      end
    end
    if (c_gnt) begin
      state_d = CORE;
    end else if (d_gnt) begin
      state_d = DBG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  dmem_arb_sat_cnt #(.MAX(STARVE_MAX), .W(SW)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (d_valid && !d_gnt),
    .clr_i (d_gnt),
    .cnt_o (starve_cnt)
  );

  dmem_arb_sat_cnt #(.MAX(LOCK_MAX), .W(LW)) u_lock_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (d_gnt && d_lock),
    .clr_i (c_gnt || !d_lock),
    .cnt_o (lock_cnt)
  );

  // Memory side follows the granted port; idle bus is driven to zero.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (c_gnt) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_wd   = c_wdata;
    end else if (d_gnt) begin
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_wd   = d_wdata;
    end
  end

  // Load data is captured at the grant edge and flagged valid for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= c_gnt && !c_we;
      d_rvalid_q <= d_gnt && !d_we;
      if (c_gnt && !c_we) begin
        c_rdata_q <= mem_rd;
      end
      if (d_gnt && !d_we) begin
        d_rdata_q <= mem_rd;
      end
    end
  end

  assign c_ready  = c_gnt;
  assign d_ready  = d_gnt;
  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
